// File: rtl/cmd_uart_if.sv
// cmd_uart_if: command/response handshake between the UART command endpoint
// (slave side) and the command processor that consumes commands (master side).
interface cmd_uart_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport slave  (output cmd, cmd_rdy, resp_sent,
                  input  clr_cmd_rdy, resp, send_resp);
  modport master (input  cmd, cmd_rdy, resp_sent,
                  output clr_cmd_rdy, resp, send_resp);
endinterface

// File: rtl/cmd_uart_wrapper.sv
// cmd_uart_wrapper: robot-side endpoint of the remote command link.
// Receives 8N1 bytes on RX, pairs them (high byte first) into 16-bit commands,
// and serializes 8-bit response bytes on TX. RX and TX run independently.
// Optional feature macro: CMD_TIMEOUT_EN -- abandons a stored high byte when
// the low byte does not arrive within TIMEOUT_CYCLES, resynchronizing pairing.
module cmd_uart_wrapper #(
  parameter int BAUD_CYCLES    = 2604,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  cmd_uart_if.slave  bus
);

  localparam int CW = $clog2(BAUD_CYCLES);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);
  localparam logic [CW-1:0] STOP_FLAG = CW'(BAUD_CYCLES - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_st_e;

  // RX synchronizer and edge history
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // RX frame machine
  uart_st_e        rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_rdy;

  // Byte-pair assembly
  asm_st_e         asm_q, asm_d;
  logic [7:0]      high_q, high_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;

  // TX frame machine
  uart_st_e        tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic            resp_sent_q, resp_sent_d;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
`endif

  // Two-flop synchronizer for the asynchronous RX pin plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX next state: mid-bit sampling, glitch rejection in START, framing check in STOP
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_rdy   = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = ST_START;
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd7) rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          byte_rdy   = rx_sync_q;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Assembly next state: high byte then low byte; a set of cmd_rdy overrides a same-cycle clear
  always_comb begin
    asm_d     = asm_q;
    high_d    = high_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
`ifdef CMD_TIMEOUT_EN
    to_cnt_d  = (asm_q == WAIT_LOW) ? to_cnt_q + 1'b1 : '0;
`endif
    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (asm_q)
      WAIT_HIGH: begin
        if (byte_rdy) begin
          high_d    = rx_shift_q;
          cmd_rdy_d = 1'b0;
          asm_d     = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (byte_rdy) begin
          cmd_d     = {high_q, rx_shift_q};
          cmd_rdy_d = 1'b1;
          asm_d     = WAIT_HIGH;
        end
`ifdef CMD_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) asm_d = WAIT_HIGH;
`endif
      end
      default: asm_d = WAIT_HIGH;
    endcase
  end

  // Assembly state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= WAIT_HIGH;
      high_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      asm_q     <= asm_d;
      high_q    <= high_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  // TX next state: resp_sent rises one cycle early so it is visible during the final STOP cycle
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + 1'b1;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    resp_sent_d = resp_sent_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_d     = 1'b1;
        if (bus.send_resp) begin
          tx_shift_d  = bus.resp;
          resp_sent_d = 1'b0;
          tx_d        = 1'b0;
          tx_state_d  = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == 4'd7) begin
            tx_d       = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == STOP_FLAG) resp_sent_d = 1'b1;
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // TX state register; the line idles high and returns high immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX            = tx_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed bench for cmd_uart_wrapper with a short bit time.
module tb_cmd_uart_wrapper;
  localparam int B = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic RX    = 1'b1;
  logic TX;
  int   n_assert = 0;
  int   n_fail   = 0;

  cmd_uart_if bus();

  cmd_uart_wrapper #(.BAUD_CYCLES(B), .TIMEOUT_CYCLES(5000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .TX    (TX),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host-side 8N1 frame on RX; stop selects the stop-bit level.
  task automatic uart_send(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  // Request a response and check every bit mid-cell, resp_sent timing and
  // the ignored request in the last STOP cycle; inject adds a mid-frame request.
  task automatic tx_frame(input logic [7:0] v, input bit inject);
    int   k;
    logic e;
    bus.resp      = v;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    for (int c = 1; c <= 10 * B; c++) begin
      @(negedge clk);
      if (c % B == B / 2) begin
        k = c / B;
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : v[k-1];
        check($sformatf("tx_%02h_bit%0d", v, k), TX, e);
      end
      if (inject && c == 3 * B + 2) begin
        bus.resp      = 8'h00;
        bus.send_resp = 1'b1;
      end
      if (inject && c == 3 * B + 3) bus.send_resp = 1'b0;
      if (c == 5 * B) check("resp_sent_busy", bus.resp_sent, 1'b0);
      if (c == 10 * B - 1) begin
        check("resp_sent_last_stop", bus.resp_sent, 1'b1);
        bus.resp      = 8'hFF;
        bus.send_resp = 1'b1;
      end
    end
    bus.send_resp = 1'b0;
    check("tx_idle_after", TX, 1'b1);
    check("resp_sent_hold", bus.resp_sent, 1'b1);
  endtask

  initial begin
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp        = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1'b1);
    check("rst_cmd", bus.cmd, 16'h0000);
    check("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    check("rst_resp_sent", bus.resp_sent, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid TX frame returns TX high without a clock edge
    bus.resp      = 8'h00;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    repeat (40) @(negedge clk);
    check("tx_mid_frame_low", TX, 1'b0);
    rst_n = 1'b0;
    #1;
    check("tx_async_reset", TX, 1'b1);
    check("resp_sent_reset", bus.resp_sent, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First command pair and clear
    uart_send(8'h2A, 1'b1);
    uart_send(8'h5C, 1'b1);
    check("cmd_2A5C", bus.cmd, 16'h2A5C);
    check("rdy_2A5C", bus.cmd_rdy, 1'b1);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("rdy_cleared", bus.cmd_rdy, 1'b0);
    check("cmd_kept", bus.cmd, 16'h2A5C);

    // New high byte drops an uncleared cmd_rdy; cmd holds mid-pair
    uart_send(8'hBE, 1'b1);
    uart_send(8'hEF, 1'b1);
    check("cmd_BEEF", bus.cmd, 16'hBEEF);
    check("rdy_BEEF", bus.cmd_rdy, 1'b1);
    uart_send(8'h12, 1'b1);
    check("rdy_drop_on_high", bus.cmd_rdy, 1'b0);
    check("cmd_hold_mid_pair", bus.cmd, 16'hBEEF);
    uart_send(8'h34, 1'b1);
    check("cmd_1234", bus.cmd, 16'h1234);
    check("rdy_1234", bus.cmd_rdy, 1'b1);

    // Response frames: mid-frame request ignored, back-to-back accepted next cycle
    tx_frame(8'hA5, 1'b1);
    tx_frame(8'h5A, 1'b0);

    // RX glitch and framing error leave pairing untouched
    RX = 1'b0;
    repeat (10) @(negedge clk);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("glitch_cmd", bus.cmd, 16'h1234);
    check("glitch_rdy", bus.cmd_rdy, 1'b1);
    uart_send(8'h55, 1'b0);
    repeat (B) @(negedge clk);
    check("framing_cmd", bus.cmd, 16'h1234);
    check("framing_rdy", bus.cmd_rdy, 1'b1);
    uart_send(8'h00, 1'b1);
    check("high_00_rdy", bus.cmd_rdy, 1'b0);
    check("high_00_cmd", bus.cmd, 16'h1234);
    uart_send(8'hFF, 1'b1);
    check("cmd_00FF", bus.cmd, 16'h00FF);
    check("rdy_00FF", bus.cmd_rdy, 1'b1);

    // Concurrent RX pair and TX response
    fork
      begin
        uart_send(8'hC3, 1'b1);
        uart_send(8'h3C, 1'b1);
      end
      tx_frame(8'h81, 1'b0);
    join
    repeat (2) @(negedge clk);
    check("cmd_C33C", bus.cmd, 16'hC33C);
    check("rdy_C33C", bus.cmd_rdy, 1'b1);

    // Lost low byte followed by a long gap
    uart_send(8'h77, 1'b1);
    repeat (6000) @(negedge clk);
    uart_send(8'hAB, 1'b1);
`ifdef CMD_TIMEOUT_EN
    check("timeout_high_AB_rdy", bus.cmd_rdy, 1'b0);
    check("timeout_high_AB_cmd", bus.cmd, 16'hC33C);
    uart_send(8'hCD, 1'b1);
    check("cmd_ABCD", bus.cmd, 16'hABCD);
    check("rdy_ABCD", bus.cmd_rdy, 1'b1);
`else
    check("no_timeout_cmd_77AB", bus.cmd, 16'h77AB);
    check("no_timeout_rdy", bus.cmd_rdy, 1'b1);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
